// File: rtl/ddr3_traffic_checker.sv
// ddr3_traffic_checker
//
// Start-triggered write/read-back traffic checker for the DDR3 controller user port.
// One pass writes NUM_WORDS words from BASE_ADDR upward (address wraps at 2^ADDR_WIDTH).
// It then reads them back in the same order, one read at a time, and compares each
// return against the pattern selected at start.
//
// Ports:
//   clk, reset             host clock; synchronous active-high reset
//   start                  one-cycle pulse, begins a pass from idle or done
//   mode                   0 incrementing, 1 walking-one, 2 LFSR, 3 inverted index
//   user_ready             controller accepts the pending command this cycle
//   write_enable           write command request (address/data held until accepted)
//   read_enable            read command request (address held until accepted)
//   i_user_data_address    command address
//   i_user_data            write data
//   o_user_data            read return data
//   o_user_data_valid      read return strobe; ignored unless a read is outstanding
//   busy                   pass in progress
//   done                   pass finished; held until the next start
//   pass                   done with no mismatches and no timeout
//   error_count            saturating mismatch count
//   first_err_addr         address of the first mismatch
//   timeout                a read return did not arrive within TIMEOUT_CYCLES
module ddr3_traffic_checker #(
    parameter int unsigned ADDR_WIDTH     = 18,
    parameter int unsigned DQ_BITWIDTH    = 16,
    parameter int unsigned NUM_WORDS      = 256,
    parameter int unsigned BASE_ADDR      = 0,
    parameter int unsigned ERR_CNT_WIDTH  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [1:0]               mode,
    input  logic                     user_ready,
    output logic                     write_enable,
    output logic                     read_enable,
    output logic [ADDR_WIDTH-1:0]    i_user_data_address,
    output logic [DQ_BITWIDTH-1:0]   i_user_data,
    input  logic [DQ_BITWIDTH-1:0]   o_user_data,
    input  logic                     o_user_data_valid,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [ERR_CNT_WIDTH-1:0] error_count,
    output logic [ADDR_WIDTH-1:0]    first_err_addr,
    output logic                     timeout
);

    localparam int unsigned TIMER_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned SHIFT_WIDTH = $clog2(DQ_BITWIDTH);

    localparam logic [ADDR_WIDTH-1:0]  LAST_IDX  = ADDR_WIDTH'(NUM_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0]  BASE      = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [TIMER_WIDTH-1:0] TIMER_MAX = TIMER_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [DQ_BITWIDTH-1:0] LFSR_SEED = '1;
    // Galois right-shift feedback masks:
    // x^16+x^14+x^13+x^11+1 -> 0xB400, x^8+x^6+x^5+x^4+1 -> 0xB8
    localparam logic [DQ_BITWIDTH-1:0] LFSR_TAPS =
        (DQ_BITWIDTH == 16) ? DQ_BITWIDTH'(16'hB400) : DQ_BITWIDTH'(8'hB8);

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StRdReq,
        StRdWait,
        StDone
    } state_t;

    state_t                   state_q, state_d;
    logic [1:0]               mode_q, mode_d;
    logic [ADDR_WIDTH-1:0]    idx_q, idx_d;
    logic [DQ_BITWIDTH-1:0]   lfsr_q, lfsr_d;
    logic [DQ_BITWIDTH-1:0]   exp_q, exp_d;
    logic [TIMER_WIDTH-1:0]   timer_q, timer_d;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic [ADDR_WIDTH-1:0]    first_err_q, first_err_d;
    logic                     timeout_q, timeout_d;

    logic [ADDR_WIDTH-1:0]    cur_addr;
    logic [DQ_BITWIDTH-1:0]   pattern;
    logic [DQ_BITWIDTH-1:0]   lfsr_next;

    // Pattern for the current index. DQ_BITWIDTH is a power of two, so the low
    // index bits are the walking-one position modulo the data width.
    always_comb begin
        cur_addr  = BASE + idx_q;
        lfsr_next = {1'b0, lfsr_q[DQ_BITWIDTH-1:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);
        case (mode_q)
            2'd0:    pattern = DQ_BITWIDTH'(idx_q);
            2'd1:    pattern = DQ_BITWIDTH'(1) << idx_q[SHIFT_WIDTH-1:0];
            2'd2:    pattern = lfsr_q;
            default: pattern = ~DQ_BITWIDTH'(idx_q);
        endcase
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        idx_d       = idx_q;
        lfsr_d      = lfsr_q;
        exp_d       = exp_q;
        timer_d     = timer_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        timeout_d   = timeout_q;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d     = StWrite;
                    mode_d      = mode;
                    idx_d       = '0;
                    lfsr_d      = LFSR_SEED;
                    timer_d     = '0;
                    err_cnt_d   = '0;
                    first_err_d = '0;
                    timeout_d   = 1'b0;
                end
            end

            StWrite: begin
                if (user_ready) begin
                    if (idx_q == LAST_IDX) begin
                        // Read-back replays the same sequence from the seed.
                        state_d = StRdReq;
                        idx_d   = '0;
                        lfsr_d  = LFSR_SEED;
                    end else begin
                        idx_d  = idx_q + ADDR_WIDTH'(1);
                        lfsr_d = lfsr_next;
                    end
                end
            end

            StRdReq: begin
                if (user_ready) begin
                    // Capture the expected word now: the LFSR moves on with the accept.
                    state_d = StRdWait;
                    exp_d   = pattern;
                    lfsr_d  = lfsr_next;
                    timer_d = '0;
                end
            end

            StRdWait: begin
                if (o_user_data_valid) begin
                    if (o_user_data != exp_q) begin
                        if (err_cnt_q == '0) begin
                            first_err_d = cur_addr;
                        end
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = StDone;
                    end else begin
                        state_d = StRdReq;
                        idx_d   = idx_q + ADDR_WIDTH'(1);
                    end
                end else if (timer_q == TIMER_MAX) begin
                    state_d   = StDone;
                    timeout_d = 1'b1;
                end else begin
                    timer_d = timer_q + TIMER_WIDTH'(1);
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            mode_q      <= '0;
            idx_q       <= '0;
            lfsr_q      <= LFSR_SEED;
            exp_q       <= '0;
            timer_q     <= '0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            idx_q       <= idx_d;
            lfsr_q      <= lfsr_d;
            exp_q       <= exp_d;
            timer_q     <= timer_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            timeout_q   <= timeout_d;
        end
    end

    // Command buses are zero whenever no command is requested.
    always_comb begin
        write_enable        = (state_q == StWrite);
        read_enable         = (state_q == StRdReq);
        i_user_data_address = (write_enable || read_enable) ? cur_addr : '0;
        i_user_data         = write_enable ? pattern : '0;
        busy                = (state_q == StWrite) || (state_q == StRdReq) ||
                              (state_q == StRdWait);
        done                = (state_q == StDone);
        pass                = done && (err_cnt_q == '0) && !timeout_q;
        error_count         = err_cnt_q;
        first_err_addr      = first_err_q;
        timeout             = timeout_q;
    end

endmodule
